chunked_adder_seq: RTL and testbench

- Multi-cycle N-bit adder/subtractor that ripples carry through a CHUNK-bit adder slice, one slice per clock.
- Successor to the combinational 4-bit adder: parametrised width and chunk size, add/sub mode, signed overflow flag, valid/ready handshake on input and output.
- Used where wide adds must not close timing in one cycle.

---
 rtl/chunked_adder_seq_if.sv | 27 ++
 rtl/chunked_adder_seq.sv | 122 ++++++++++++
 tb/tb_chunked_adder_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/chunked_adder_seq_if.sv
// Operand/result handshake bundle for chunked_adder_seq.
// The requester drives the master side and the adder sits on the slave side.
interface chunked_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );
endinterface

// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples the carry through one
// CHUNK-bit slice per clock, with valid/ready handshakes on both sides.
module chunked_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                i_clk,
    input logic                i_rst_n,
    chunked_adder_seq_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    int                chunkBase;
    logic [CHUNK-1:0]  aChunk;
    logic [CHUNK-1:0]  bChunk;
    logic [CHUNK-1:0]  chunkSum;
    logic              chunkCout;
    logic              carryIntoMsb;

    // Shifts rather than variable part-selects keep the slice extraction width-clean.
    always_comb begin
        chunkBase = int'(idx_q) * CHUNK;
        aChunk    = CHUNK'(a_q >> chunkBase);
        bChunk    = CHUNK'(b_q >> chunkBase);
        {chunkCout, chunkSum} = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
        carryIntoMsb = aChunk[CHUNK-1] ^ bChunk[CHUNK-1] ^ chunkSum[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
                    carry_d = bus.i_sub | bus.i_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << chunkBase)) | (WIDTH'(chunkSum) << chunkBase);
                carry_d = chunkCout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunkCout;
                    ovf_d   = carryIntoMsb ^ chunkCout;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_cout  = cout_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_adder_seq.sv
// Bench for chunked_adder_seq: directed cases on 16/4, then random operations
// on 16/4, 8/8 and 32/8 against an integer-arithmetic reference model.
module tb_chunked_adder_seq;
    localparam int W0 = 16, C0 = 4;
    localparam int W1 = 8,  C1 = 8;
    localparam int W2 = 32, C2 = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    chunked_adder_seq_if #(.WIDTH(W0)) bus0 ();
    chunked_adder_seq_if #(.WIDTH(W1)) bus1 ();
    chunked_adder_seq_if #(.WIDTH(W2)) bus2 ();

    chunked_adder_seq #(.WIDTH(W0), .CHUNK(C0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    chunked_adder_seq #(.WIDTH(W1), .CHUNK(C1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
    chunked_adder_seq #(.WIDTH(W2), .CHUNK(C2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    function automatic int widthOf(input int cfg);
        return (cfg == 0) ? W0 : (cfg == 1) ? W1 : W2;
    endfunction

    function automatic int nchunkOf(input int cfg);
        return (cfg == 0) ? W0 / C0 : (cfg == 1) ? W1 / C1 : W2 / C2;
    endfunction

    task automatic driveOperands(input int cfg, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin, input logic sub);
        case (cfg)
            0: begin bus0.i_valid = v; bus0.i_a = a[15:0]; bus0.i_b = b[15:0]; bus0.i_cin = cin; bus0.i_sub = sub; end
            1: begin bus1.i_valid = v; bus1.i_a = a[7:0];  bus1.i_b = b[7:0];  bus1.i_cin = cin; bus1.i_sub = sub; end
            default: begin bus2.i_valid = v; bus2.i_a = a; bus2.i_b = b; bus2.i_cin = cin; bus2.i_sub = sub; end
        endcase
    endtask

    task automatic driveReady(input int cfg, input logic rdy);
        case (cfg)
            0: bus0.i_ready = rdy;
            1: bus1.i_ready = rdy;
            default: bus2.i_ready = rdy;
        endcase
    endtask

    function automatic void sampleOut(input int cfg, output logic v, output logic r,
                                      output logic [32:0] cs, output logic ovf);
        case (cfg)
            0: begin v = bus0.o_valid; r = bus0.o_ready; cs = 33'({bus0.o_cout, bus0.o_sum}); ovf = bus0.o_ovf; end
            1: begin v = bus1.o_valid; r = bus1.o_ready; cs = 33'({bus1.o_cout, bus1.o_sum}); ovf = bus1.o_ovf; end
            default: begin v = bus2.o_valid; r = bus2.o_ready; cs = {bus2.o_cout, bus2.o_sum}; ovf = bus2.o_ovf; end
        endcase
    endfunction

    // Reference: unsigned sum gives {cout,sum}; the signed sum leaving the
    // representable range gives overflow.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  output logic [32:0] cs, output logic ovf);
        longint mask, half, ua, ub, c, total, sa, sb, st;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(a) & mask;
        ub    = sub ? (~longint'(b)) & mask : longint'(b) & mask;
        c     = (sub || cin) ? 1 : 0;
        total = ua + ub + c;
        cs    = 33'(total);
        sa    = (ua >= half) ? ua - (mask + 1) : ua;
        sb    = (ub >= half) ? ub - (mask + 1) : ub;
        st    = sa + sb + c;
        ovf   = (st >= half) || (st < -half);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, entered and left on a falling edge.
    task automatic applyStimulus(input int cfg, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input logic rdyEarly,
                                 input int stall, input string tag);
        logic        v, r, ovf, expOvf;
        logic [32:0] cs, expCs;
        int          lat;
        model(widthOf(cfg), a, b, cin, sub, expCs, expOvf);

        sampleOut(cfg, v, r, cs, ovf);
        checkOutput({tag, "_ready_idle"}, 64'(r), 64'(1));
        driveOperands(cfg, 1'b1, a, b, cin, sub);
        driveReady(cfg, rdyEarly);
        @(negedge clk);
        driveOperands(cfg, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        lat = 0;
        sampleOut(cfg, v, r, cs, ovf);
        while (!v && lat < 64) begin
            @(negedge clk);
            lat++;
            sampleOut(cfg, v, r, cs, ovf);
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(nchunkOf(cfg)));
        checkOutput({tag, "_sum"}, 64'(cs), 64'(expCs));
        checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
        checkOutput({tag, "_ready_busy"}, 64'(r), 64'(0));

        if (!rdyEarly) begin
            for (int i = 0; i < stall; i++) begin
                driveOperands(cfg, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                @(negedge clk);
                sampleOut(cfg, v, r, cs, ovf);
                checkOutput({tag, "_stall_valid"}, 64'(v), 64'(1));
                checkOutput({tag, "_stall_sum"}, 64'(cs), 64'(expCs));
                checkOutput({tag, "_stall_ovf"}, 64'(ovf), 64'(expOvf));
                checkOutput({tag, "_stall_ready"}, 64'(r), 64'(0));
            end
            driveOperands(cfg, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
            driveReady(cfg, 1'b1);
        end
        @(negedge clk);
        sampleOut(cfg, v, r, cs, ovf);
        checkOutput({tag, "_hs_valid"}, 64'(v), 64'(0));
        checkOutput({tag, "_hs_ready"}, 64'(r), 64'(1));
        driveReady(cfg, 1'b0);
        @(negedge clk);
        sampleOut(cfg, v, r, cs, ovf);
        checkOutput({tag, "_post_valid"}, 64'(v), 64'(0));
        checkOutput({tag, "_post_ready"}, 64'(r), 64'(1));
    endtask

    initial begin
        logic        v, r, ovf;
        logic [32:0] cs;

        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            driveOperands(c, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            driveReady(c, 1'b0);
        end
        #2;
        for (int c = 0; c < 3; c++) begin
            sampleOut(c, v, r, cs, ovf);
            checkOutput($sformatf("rst%0d_valid", c), 64'(v), 64'(0));
            checkOutput($sformatf("rst%0d_ready", c), 64'(r), 64'(1));
            checkOutput($sformatf("rst%0d_sum", c), 64'(cs), 64'(0));
            checkOutput($sformatf("rst%0d_ovf", c), 64'(ovf), 64'(0));
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 32'h00FF, 32'h0001, 1'b0, 1'b0, 1'b1, 0, "basic_add");
        applyStimulus(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 1'b1, 0, "full_ripple");
        applyStimulus(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b1, 0, "pos_ovf");
        applyStimulus(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 1'b1, 0, "sub_borrow");
        applyStimulus(0, 32'h0005, 32'h0007, 1'b1, 1'b1, 1'b0, 0, "sub_borrow_cin");
        applyStimulus(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1, 0, "sub_ovf");
        applyStimulus(0, 32'h8000, 32'h0001, 1'b1, 1'b1, 1'b1, 0, "sub_ovf_cin");
        applyStimulus(0, 32'hA5C3, 32'h1E2F, 1'b1, 1'b0, 1'b0, 5, "backpressure");

        // Reset lands mid-RUN, between clock edges.
        driveOperands(0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0);
        driveReady(0, 1'b1);
        @(negedge clk);
        driveOperands(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sampleOut(0, v, r, cs, ovf);
        checkOutput("midrst_valid", 64'(v), 64'(0));
        checkOutput("midrst_ready", 64'(r), 64'(1));
        checkOutput("midrst_sum", 64'(cs), 64'(0));
        checkOutput("midrst_ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        driveReady(0, 1'b0);
        applyStimulus(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 1'b1, 0, "after_reset");

        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 32; i++) begin
                applyStimulus(c, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                              $sformatf("rnd%0d_%0d", c, i));
                if (failures != 0) begin
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $fatal(1, "[TB] stopping at first random-check error");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
